cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control FSM for the ARM32 datapath. It owns the instruction loop: fetch over a ready-handshaked RAM port, then decode, operand load, ALU execute, memory access and writeback. It adds conditional/linked branches, pre/post-indexed load/store and a wait-state timeout. It drives the register file, ALU, shifter, status register, PC and RAM address register enables; the opcode is supplied by the instruction decoder from the IR.

## Interface
- TIMEOUT, 0: maximum cycles a RAM request may stay unacknowledged; 0 disables the check.
- Z_BIT, 30: index of the Z flag in `status_reg`.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- opcode  in  7  decoded opcode, valid from DECODE onward.
- shift_op_in  in  2  decoder shift type for R/RS-type ALU ops.
- status_reg  in  32  NZCV status word.
- ram_ready  in  1  RAM acknowledges the current request this cycle.
- waiting  out  1  high in every state except HALT.
- halted, error  out  1 each  in HALT; error means HALT was entered by timeout.
- wb_sel  out  2  writeback source: 00 ALU C, 01 RAM data, 10 immediate, 11 PC.
- w_addr_sel  out  2  write target: 00 rd, 01 rn, 10 r14.
- pc_sel  out  2  PC source: 00 PC+4, 01 PC+imm, 10 B register.
- alu_op  out  3  ADD 000, SUB 001, AND 010, ORR 011, XOR 111.
- shift_op  out  2  shifter type.
- sel_A, sel_B, sel_shift, w_en, en_A, en_B, en_C, en_status, en_S  out  1 each  datapath controls.
- load_ir, load_pc, clear_pc, load_addr, sel_addr, ram_req, ram_w_en  out  1 each  fetch, PC and memory controls.

## Operation
- **Opcode classes**
  - Regular: bit6=0. Bits 5:4 give the type: 01 I, 10 R, 11 RS. Bit3=1 selects the move/shift group.
  - Regular ops, bits 2:0: 000 ADD, 001 SUB, 010 CMP, 011 AND, 100 ORR, 101 EOR.
  - Move/shift group, bits 2:0: 000 MOV, 001 LSL, 010 LSR, 011 ASR, 100 ROR.
  - 0000000 is NOP; 0000001 is HLT.
  - Branch: bits 6:3 = 1000. Bits 2:0: B, BX, BL, BLX, BEQ, BNE.
  - Load/store: bits 6:5 = 11. Bit4 L (1 = load), bit3 P (pre-index), bit2 U (add offset), bit1 W (write back base).
- **Default outputs:** every output is 0 unless listed for the current state. `waiting`=1 outside HALT.
- **RESET:** `clear_pc`=1. Always goes to FETCH.
- **FETCH:** `load_addr`=1, `sel_addr`=0, `ram_req`=1. Goes to FETCH_WAIT.
- **FETCH_WAIT:** `ram_req`=1. On `ram_ready`: `load_ir`=1, `load_pc`=1, `pc_sel`=00, go to DECODE.
- **DECODE:**
  - NOP goes to FETCH; HLT goes to HALT.
  - I-type MOV goes to WRITEBACK.
  - B, BL, BEQ, BNE go to BRANCH.
  - Every other opcode goes to LOAD_OPS. Unknown opcodes go to FETCH, treated as NOP.
- **LOAD_OPS:**
  - `en_A`=1 for regular ops with bit3=0, and for load/store.
  - `en_B`=`en_S`=1 for R/RS types, and for BX/BLX. `sel_shift`=1 for RS type.
  - BX/BLX then go to BRANCH; all others go to EXEC.
- **EXEC:**
  - `sel_A`=1 for the move/shift group. `sel_B`=1 for I-type and for load/store.
  - `alu_op`: load/store uses U ? ADD : SUB. CMP uses SUB.
  - `shift_op` = opcode[1:0]−1 for shift ops, else `shift_op_in`.
  - CMP: `en_status`=1, `en_C`=0, then FETCH. Otherwise `en_C`=1.
  - Load/store then goes to MEM; regular ops go to WRITEBACK.
- **MEM:**
  - `load_addr`=1 on the first cycle only. `sel_addr`=P.
  - `ram_req`=1 and `ram_w_en`=!L, held until `ram_ready`.
  - After `ram_ready`: loads go to WRITEBACK; stores go to WB_BASE if W|!P, else FETCH.
- **WRITEBACK:** `w_en`=1, `w_addr_sel`=00.
  - `wb_sel`: 10 for I-type MOV, 01 for loads, 00 otherwise.
  - Loads with W|!P go to WB_BASE; everything else goes to FETCH.
- **WB_BASE:** `w_en`=1, `wb_sel`=00, `w_addr_sel`=01. Goes to FETCH.
- **BRANCH:**
  - Taken for B, BX, BL, BLX always; BEQ when Z=1; BNE when Z=0.
  - Taken: `load_pc`=1. `pc_sel`=10 for BX/BLX, else 01.
  - BL/BLX: `w_en`=1, `wb_sel`=11, `w_addr_sel`=10, applied whether taken or not. PC already holds the return address.
  - Goes to FETCH.
- **HALT:** `halted`=1, `waiting`=0. Absorbing; only reset exits.
- **Timeout counter:** counts consecutive cycles with `ram_req`=1 and `ram_ready`=0, and clears when `ram_ready`=1. When TIMEOUT≠0 and the count reaches TIMEOUT, the FSM goes to HALT with `error`=1, set and held until reset.

## Timing
- Async reset: state=RESET, counter=0, `error`=0. Outputs are combinational, so `waiting`=1 and `clear_pc`=1 immediately.
- Per-instruction cycles with zero-wait RAM (`ram_ready` high on the first FETCH_WAIT cycle):
  - NOP: 3.
  - I-MOV: 4.
  - CMP: 5.
  - R/RS/shift ALU op: 6.
  - B/BEQ/BNE: 4; BX/BLX: 5.
  - Store without writeback: 6.
  - Load with writeback: 8.
- Each extra RAM wait cycle adds one cycle.
- `ram_ready` is ignored when `ram_req`=0.
- `status_reg` is sampled in BRANCH, so a CMP immediately before a branch is honoured.
- Reset mid-MEM drops `ram_req` asynchronously; no write completes after reset.

## Test plan
- rst_n pulse low mid-cycle → `clear_pc`=1 and `waiting`=1 immediately. With `ram_ready`=1 and R-type ADD 0100000: states RESET, FETCH, FETCH_WAIT, DECODE, LOAD_OPS, EXEC, WRITEBACK; `w_en`=1 for one cycle, `wb_sel`=00.
- CMP 0110010 → `en_status`=1, `en_C`=0 in EXEC; no `w_en` pulse; next FETCH follows 5 cycles after the previous one.
- BEQ with status_reg=0x40000000, then 0x00000000 → `load_pc`=1 with `pc_sel`=01 in the first case, no `load_pc` in the second. BL → `w_en`=1, `wb_sel`=11, `w_addr_sel`=10.
- Load 1110010 (P=0, post-index) with `ram_ready` delayed 3 cycles → `ram_req` held 4 cycles with `sel_addr`=0, then WRITEBACK (`wb_sel`=01), then WB_BASE (`w_addr_sel`=01).
- TIMEOUT=4, `ram_ready` stuck at 0 in FETCH_WAIT → HALT entered after the 4th unacknowledged cycle; `error`=1, `waiting`=0; reset clears `error`.
- HLT 0000001 → `halted`=1 and stays there for 100 cycles regardless of opcode and `ram_ready`.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// RAM request/acknowledge bundle between the instruction sequencer and the
// memory port, including the RAM address register controls.
interface cpu_sequencer_if;
    logic ram_req;    // request outstanding this cycle
    logic ram_w_en;   // 1 = write request, 0 = read request
    logic ram_ready;  // memory acknowledges the current request
    logic load_addr;  // capture the RAM address register
    logic sel_addr;   // RAM address source select

    modport master (
        output ram_req, ram_w_en, load_addr, sel_addr,
        input  ram_ready
    );

    modport slave (
        input  ram_req, ram_w_en, load_addr, sel_addr,
        output ram_ready
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the ARM32 datapath: fetch, decode, operand load,
// execute, memory access and writeback, with branches, indexed load/store and
// a RAM wait-state timeout that parks the machine in HALT with error set.
module cpu_sequencer #(
    parameter int TIMEOUT = 0,   // max unacknowledged RAM cycles, 0 = no limit
    parameter int Z_BIT   = 30   // Z flag position in status_reg
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic [1:0]      shift_op_in,
    input  logic [31:0]     status_reg,
    cpu_sequencer_if.master bus,
    output logic            waiting,
    output logic            halted,
    output logic            error,
    output logic [1:0]      wb_sel,
    output logic [1:0]      w_addr_sel,
    output logic [1:0]      pc_sel,
    output logic [2:0]      alu_op,
    output logic [1:0]      shift_op,
    output logic            sel_A,
    output logic            sel_B,
    output logic            sel_shift,
    output logic            w_en,
    output logic            en_A,
    output logic            en_B,
    output logic            en_C,
    output logic            en_status,
    output logic            en_S,
    output logic            load_ir,
    output logic            load_pc,
    output logic            clear_pc
);

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_FETCH_WAIT, S_DECODE, S_LOAD_OPS, S_EXEC,
        S_MEM, S_WRITEBACK, S_WB_BASE, S_BRANCH, S_HALT
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            error_q, error_d;
    logic            mem_wait_q, mem_wait_d;   // MEM already spent one cycle

    logic ram_req, ram_w_en, load_addr, sel_addr;
    logic timeout_hit;

    // ---------------- opcode decode ----------------
    logic is_reg, is_itype, is_rtype, is_rs, is_mvgrp, is_cmp, is_shift;
    logic is_imov, is_hlt;
    logic is_br, br_reg, br_link, br_taken, z_flag;
    logic is_ls, ls_l, ls_p, ls_u, ls_w, ls_base_wb;

    assign is_reg   = !opcode[6] && (opcode[5:4] != 2'b00) &&
                      (opcode[3] ? (opcode[2:0] <= 3'd4) : (opcode[2:0] <= 3'd5));
    assign is_itype = is_reg && (opcode[5:4] == 2'b01);
    assign is_rtype = is_reg && opcode[5];             // R and RS both read B
    assign is_rs    = is_reg && (opcode[5:4] == 2'b11);
    assign is_mvgrp = is_reg && opcode[3];
    assign is_cmp   = is_reg && !opcode[3] && (opcode[2:0] == 3'b010);
    assign is_shift = is_mvgrp && (opcode[2:0] != 3'b000);
    assign is_imov  = (opcode == 7'b0011000);
    assign is_hlt   = (opcode == 7'b0000001);

    assign is_br    = (opcode[6:3] == 4'b1000) && (opcode[2:0] <= 3'd5);
    assign br_reg   = is_br && !opcode[2] && opcode[0];   // BX, BLX
    assign br_link  = is_br && !opcode[2] && opcode[1];   // BL, BLX
    assign z_flag   = status_reg[Z_BIT];
    assign br_taken = is_br && (!opcode[2] || (opcode[0] ? !z_flag : z_flag));

    assign is_ls      = (opcode[6:5] == 2'b11);
    assign ls_l       = opcode[4];
    assign ls_p       = opcode[3];
    assign ls_u       = opcode[2];
    assign ls_w       = opcode[1];
    assign ls_base_wb = ls_w || !ls_p;

    // Only the Z flag steers the sequencer; the remaining status bits are
    // deliberately left unused.
    logic unused_status;
    assign unused_status = ^status_reg;

    // Regular-op function field to ALU encoding (CMP shares SUB).
    function automatic logic [2:0] reg_alu_op(input logic [2:0] f);
        case (f)
            3'b001, 3'b010: reg_alu_op = 3'b001;
            3'b011:         reg_alu_op = 3'b010;
            3'b100:         reg_alu_op = 3'b011;
            3'b101:         reg_alu_op = 3'b111;
            default:        reg_alu_op = 3'b000;
        endcase
    endfunction

    // State, wait-state counter, sticky error and MEM first-cycle flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RESET;
            cnt_q      <= '0;
            error_q    <= 1'b0;
            mem_wait_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            error_q    <= error_d;
            mem_wait_q <= mem_wait_d;
        end
    end

    // Next state, including the timeout override into HALT.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d     = state_q;
        cnt_d       = '0;
        timeout_hit = 1'b0;

        if (ram_req && !bus.ram_ready) begin
            cnt_d       = (cnt_q != TO_LAST) ? cnt_q + CW'(1) : cnt_q;
            timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
        end

        case (state_q)
            S_RESET:      state_d = S_FETCH;
            S_FETCH:      state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: if (bus.ram_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (is_hlt)                     state_d = S_HALT;
                else if (is_imov)               state_d = S_WRITEBACK;
                else if (is_br && !br_reg)      state_d = S_BRANCH;
                else if (is_reg || is_ls || br_reg) state_d = S_LOAD_OPS;
                else                            state_d = S_FETCH;
            end
            S_LOAD_OPS:   state_d = br_reg ? S_BRANCH : S_EXEC;
            S_EXEC: begin
                if (is_ls)       state_d = S_MEM;
                else if (is_cmp) state_d = S_FETCH;
                else             state_d = S_WRITEBACK;
            end
            S_MEM: begin
                if (bus.ram_ready) begin
                    if (ls_l)            state_d = S_WRITEBACK;
                    else if (ls_base_wb) state_d = S_WB_BASE;
                    else                 state_d = S_FETCH;
                end
            end
            S_WRITEBACK:  state_d = (is_ls && ls_l && ls_base_wb) ? S_WB_BASE : S_FETCH;
            S_WB_BASE:    state_d = S_FETCH;
            S_BRANCH:     state_d = S_FETCH;
            S_HALT:       state_d = S_HALT;
            default:      state_d = S_RESET;
        endcase

        if (timeout_hit) state_d = S_HALT;

        error_d    = error_q || timeout_hit;
        mem_wait_d = (state_q == S_MEM) && (state_d == S_MEM);
    end

    // Datapath and memory controls decoded from the current state.
    always_comb begin
        wb_sel     = 2'b00;
        w_addr_sel = 2'b00;
        pc_sel     = 2'b00;
        alu_op     = 3'b000;
        shift_op   = 2'b00;
        sel_A      = 1'b0;
        sel_B      = 1'b0;
        sel_shift  = 1'b0;
        w_en       = 1'b0;
        en_A       = 1'b0;
        en_B       = 1'b0;
        en_C       = 1'b0;
        en_status  = 1'b0;
        en_S       = 1'b0;
        load_ir    = 1'b0;
        load_pc    = 1'b0;
        clear_pc   = 1'b0;
        load_addr  = 1'b0;
        sel_addr   = 1'b0;
        ram_req    = 1'b0;
        ram_w_en   = 1'b0;

        case (state_q)
            S_RESET: clear_pc = 1'b1;
            S_FETCH: begin
                load_addr = 1'b1;
                ram_req   = 1'b1;
            end
            S_FETCH_WAIT: begin
                ram_req = 1'b1;
                if (bus.ram_ready) begin
                    load_ir = 1'b1;
                    load_pc = 1'b1;
                end
            end
            S_LOAD_OPS: begin
                en_A      = (is_reg && !opcode[3]) || is_ls;
                en_B      = is_rtype || br_reg;
                en_S      = is_rtype || br_reg;
                sel_shift = is_rs;
            end
            S_EXEC: begin
                sel_A     = is_mvgrp;
                sel_B     = is_itype || is_ls;
                if (is_ls)          alu_op = ls_u ? 3'b000 : 3'b001;
                else if (!opcode[3]) alu_op = reg_alu_op(opcode[2:0]);
                shift_op  = is_shift ? (opcode[1:0] - 2'd1) : shift_op_in;
                en_status = is_cmp;
                en_C      = !is_cmp;
            end
            S_MEM: begin
                load_addr = !mem_wait_q;
                sel_addr  = ls_p;
                ram_req   = 1'b1;
                ram_w_en  = !ls_l;
            end
            S_WRITEBACK: begin
                w_en = 1'b1;
                if (is_imov)            wb_sel = 2'b10;
                else if (is_ls && ls_l) wb_sel = 2'b01;
            end
            S_WB_BASE: begin
                w_en       = 1'b1;
                w_addr_sel = 2'b01;
            end
            S_BRANCH: begin
                if (br_taken) begin
                    load_pc = 1'b1;
                    pc_sel  = br_reg ? 2'b10 : 2'b01;
                end
                // PC already holds the return address, link regardless of taken.
                if (br_link) begin
                    w_en       = 1'b1;
                    wb_sel     = 2'b11;
                    w_addr_sel = 2'b10;
                end
            end
            default: ;
        endcase
    end

    assign waiting       = (state_q != S_HALT);
    assign halted        = (state_q == S_HALT);
    assign error         = error_q;
    assign bus.ram_req   = ram_req;
    assign bus.ram_w_en  = ram_w_en;
    assign bus.load_addr = load_addr;
    assign bus.sel_addr  = sel_addr;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: walks instructions cycle by cycle and
// compares controls against hand-derived values.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [1:0]  shift_op_in;
    logic [31:0] status_reg;
    logic        waiting, halted, error;
    logic [1:0]  wb_sel, w_addr_sel, pc_sel, shift_op;
    logic [2:0]  alu_op;
    logic        sel_A, sel_B, sel_shift, w_en, en_A, en_B, en_C, en_status, en_S;
    logic        load_ir, load_pc, clear_pc;

    int n_vec = 0;
    int n_err = 0;
    int wen_cnt = 0;
    int w0;

    cpu_sequencer_if bus ();

    cpu_sequencer #(.TIMEOUT(4), .Z_BIT(30)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .shift_op_in(shift_op_in),
        .status_reg(status_reg), .bus(bus),
        .waiting(waiting), .halted(halted), .error(error),
        .wb_sel(wb_sel), .w_addr_sel(w_addr_sel), .pc_sel(pc_sel),
        .alu_op(alu_op), .shift_op(shift_op),
        .sel_A(sel_A), .sel_B(sel_B), .sel_shift(sel_shift), .w_en(w_en),
        .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_status(en_status), .en_S(en_S),
        .load_ir(load_ir), .load_pc(load_pc), .clear_pc(clear_pc)
    );

    always #5 clk = ~clk;

    // Count register-write cycles, sampled mid-cycle.
    always @(negedge clk) if (w_en) wen_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; returns 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 7'b0; shift_op_in = 2'b10;
        status_reg = 32'h0; bus.ram_ready = 1'b0;
        #3;
        check("rst_clear_pc", clear_pc, 1);
        check("rst_waiting", waiting, 1);
        check("rst_halted", halted, 0);
        check("rst_error", error, 0);
        check("rst_ram_req", bus.ram_req, 0);
        step();
        rst_n = 1'b1; bus.ram_ready = 1'b1; opcode = 7'b0100000;
        #1;
        check("rst_hold_clear_pc", clear_pc, 1);

        // R-type ADD: F FW D LO EX WB
        step();
        check("add_f_load_addr", bus.load_addr, 1);
        check("add_f_ram_req", bus.ram_req, 1);
        check("add_f_sel_addr", bus.sel_addr, 0);
        check("add_f_clear_pc", clear_pc, 0);
        step();
        check("add_fw_load_ir", load_ir, 1);
        check("add_fw_load_pc", load_pc, 1);
        check("add_fw_pc_sel", pc_sel, 0);
        w0 = wen_cnt;
        step();
        check("add_d_w_en", w_en, 0);
        check("add_d_ram_req", bus.ram_req, 0);
        step();
        check("add_lo_en_A", en_A, 1);
        check("add_lo_en_B", en_B, 1);
        check("add_lo_en_S", en_S, 1);
        check("add_lo_sel_shift", sel_shift, 0);
        step();
        check("add_ex_en_C", en_C, 1);
        check("add_ex_alu_op", alu_op, 3'b000);
        check("add_ex_shift_op", shift_op, 2'b10);
        check("add_ex_sel_B", sel_B, 0);
        step();
        check("add_wb_w_en", w_en, 1);
        check("add_wb_wb_sel", wb_sel, 2'b00);
        check("add_wb_w_addr_sel", w_addr_sel, 2'b00);
        step();
        check("add_next_fetch", bus.load_addr, 1);
        check("add_wen_pulses", wen_cnt - w0, 1);

        // RS-type CMP: 5 cycles fetch to fetch, no register write
        opcode = 7'b0110010; w0 = wen_cnt;
        step(); step(); step();
        check("cmp_lo_en_A", en_A, 1);
        check("cmp_lo_sel_shift", sel_shift, 1);
        step();
        check("cmp_ex_en_status", en_status, 1);
        check("cmp_ex_en_C", en_C, 0);
        check("cmp_ex_alu_op", alu_op, 3'b001);
        step();
        check("cmp_next_fetch", bus.load_addr, 1);
        check("cmp_wen_pulses", wen_cnt - w0, 0);

        // BEQ taken (Z=1)
        opcode = 7'b1000100; status_reg = 32'h4000_0000;
        step(); step(); step();
        check("beq_t_load_pc", load_pc, 1);
        check("beq_t_pc_sel", pc_sel, 2'b01);
        check("beq_t_w_en", w_en, 0);
        step();
        check("beq_t_next_fetch", bus.load_addr, 1);

        // BEQ not taken (Z=0)
        status_reg = 32'h0;
        step(); step(); step();
        check("beq_nt_load_pc", load_pc, 0);
        step();

        // BNE taken (Z=0)
        opcode = 7'b1000101;
        step(); step(); step();
        check("bne_t_load_pc", load_pc, 1);
        step();

        // BL: link write plus taken branch
        opcode = 7'b1000010;
        step(); step(); step();
        check("bl_w_en", w_en, 1);
        check("bl_wb_sel", wb_sel, 2'b11);
        check("bl_w_addr_sel", w_addr_sel, 2'b10);
        check("bl_load_pc", load_pc, 1);
        check("bl_pc_sel", pc_sel, 2'b01);
        step();

        // BX: operand load then branch from B
        opcode = 7'b1000001;
        step(); step(); step();
        check("bx_lo_en_B", en_B, 1);
        check("bx_lo_en_S", en_S, 1);
        check("bx_lo_en_A", en_A, 0);
        step();
        check("bx_br_load_pc", load_pc, 1);
        check("bx_br_pc_sel", pc_sel, 2'b10);
        step();
        check("bx_next_fetch", bus.load_addr, 1);

        // I-type MOV: 4 cycles, immediate writeback
        opcode = 7'b0011000;
        step(); step(); step();
        check("imov_w_en", w_en, 1);
        check("imov_wb_sel", wb_sel, 2'b10);
        step();
        check("imov_next_fetch", bus.load_addr, 1);

        // RS-type ROR
        opcode = 7'b0111100;
        step(); step(); step();
        check("ror_lo_en_A", en_A, 0);
        check("ror_lo_en_B", en_B, 1);
        check("ror_lo_sel_shift", sel_shift, 1);
        step();
        check("ror_ex_sel_A", sel_A, 1);
        check("ror_ex_shift_op", shift_op, 2'b11);
        check("ror_ex_en_C", en_C, 1);
        step();
        check("ror_wb_w_en", w_en, 1);
        step();

        // Unknown opcode behaves as NOP (3 cycles)
        opcode = 7'b1001000;
        step(); step();
        check("unk_d_ram_req", bus.ram_req, 0);
        step();
        check("unk_next_fetch", bus.load_addr, 1);

        // Store, pre-index, add, no writeback: 6 cycles
        opcode = 7'b1101100;
        step(); step(); step();
        check("st_lo_en_A", en_A, 1);
        check("st_lo_en_B", en_B, 0);
        step();
        check("st_ex_sel_B", sel_B, 1);
        check("st_ex_alu_op", alu_op, 3'b000);
        step();
        check("st_mem_ram_req", bus.ram_req, 1);
        check("st_mem_w_en", bus.ram_w_en, 1);
        check("st_mem_sel_addr", bus.sel_addr, 1);
        check("st_mem_load_addr", bus.load_addr, 1);
        step();
        check("st_next_fetch_w_en", bus.ram_w_en, 0);
        check("st_next_fetch_sel", bus.sel_addr, 0);
        check("st_next_fetch", bus.load_addr, 1);

        // Load, post-index, subtract, writeback; RAM acks on 4th MEM cycle
        opcode = 7'b1110010;
        step(); step(); step(); step();
        check("ld_ex_alu_op", alu_op, 3'b001);
        check("ld_ex_sel_B", sel_B, 1);
        #1 bus.ram_ready = 1'b0;
        step();
        check("ld_mem1_load_addr", bus.load_addr, 1);
        check("ld_mem1_sel_addr", bus.sel_addr, 0);
        check("ld_mem1_ram_req", bus.ram_req, 1);
        check("ld_mem1_ram_w_en", bus.ram_w_en, 0);
        step();
        check("ld_mem2_load_addr", bus.load_addr, 0);
        check("ld_mem2_ram_req", bus.ram_req, 1);
        step();
        check("ld_mem3_ram_req", bus.ram_req, 1);
        step();
        bus.ram_ready = 1'b1;
        #1;
        check("ld_mem4_ram_req", bus.ram_req, 1);
        check("ld_mem4_sel_addr", bus.sel_addr, 0);
        step();
        check("ld_wb_w_en", w_en, 1);
        check("ld_wb_wb_sel", wb_sel, 2'b01);
        check("ld_wb_w_addr_sel", w_addr_sel, 2'b00);
        check("ld_wb_halted", halted, 0);
        step();
        check("ld_base_w_en", w_en, 1);
        check("ld_base_wb_sel", wb_sel, 2'b00);
        check("ld_base_w_addr_sel", w_addr_sel, 2'b01);
        step();
        check("ld_next_fetch", bus.load_addr, 1);

        // Reset pulse in the middle of a store's MEM cycle
        opcode = 7'b1101100;
        step(); step(); step(); step();
        #1 bus.ram_ready = 1'b0;
        step();
        check("rmem_ram_req_before", bus.ram_req, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rmem_ram_req", bus.ram_req, 0);
        check("rmem_ram_w_en", bus.ram_w_en, 0);
        check("rmem_clear_pc", clear_pc, 1);
        check("rmem_waiting", waiting, 1);
        step();
        rst_n = 1'b1;

        // Timeout: ack in FETCH, then stuck low in FETCH_WAIT
        bus.ram_ready = 1'b1; opcode = 7'b0100000;
        step();
        check("to_fetch", bus.load_addr, 1);
        step();
        bus.ram_ready = 1'b0;
        #1;
        check("to_fw1_ram_req", bus.ram_req, 1);
        check("to_fw1_load_ir", load_ir, 0);
        step(); step(); step();
        check("to_fw4_halted", halted, 0);
        check("to_fw4_ram_req", bus.ram_req, 1);
        step();
        check("to_halted", halted, 1);
        check("to_error", error, 1);
        check("to_waiting", waiting, 0);
        check("to_ram_req", bus.ram_req, 0);
        #1 rst_n = 1'b0;
        #1;
        check("to_rst_error", error, 0);
        check("to_rst_halted", halted, 0);
        check("to_rst_waiting", waiting, 1);
        step();
        rst_n = 1'b1;

        // HLT: absorbing for 100 cycles whatever the inputs do
        opcode = 7'b0000001; bus.ram_ready = 1'b1;
        step(); step(); step(); step();
        check("hlt_halted", halted, 1);
        check("hlt_error", error, 0);
        check("hlt_waiting", waiting, 0);
        for (int i = 0; i < 100; i++) begin
            opcode = 7'($urandom);
            bus.ram_ready = 1'($urandom);
            step();
            check("hlt_stay", halted, 1);
        end
        check("hlt_end_ram_req", bus.ram_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
